// File: rtl/myproject_dense_acc_relu.sv
// Dense-layer neuron tail: sums N_TERMS signed products plus bias, then applies
// round-half-up shift, ReLU and saturation, and holds the result under valid/ready.
module myproject_dense_acc_relu #(
  parameter int DIN_WIDTH  = 23,
  parameter int N_TERMS    = 9,
  parameter int ACC_WIDTH  = 27,
  parameter int BIAS_WIDTH = 16,
  parameter int SHIFT      = 7,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic signed [DIN_WIDTH-1:0]  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DOUT_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sat_flag
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int PW    = ACC_WIDTH + 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [PW-1:0] HALF     = PW'(longint'(1) << (SHIFT - 1));
  localparam logic signed [PW-1:0] MAX_OUT  = PW'((longint'(1) << (DOUT_WIDTH - 1)) - 1);

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  logic [0:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [DOUT_WIDTH-1:0]       r_out_data;
  logic                        r_sat;

  logic                        w_in_xfer;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic signed [ACC_WIDTH-1:0] w_din_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [PW-1:0]        w_rnd;
  logic signed [PW-1:0]        w_shr;
  logic                        w_neg;
  logic                        w_ovf;
  logic [DOUT_WIDTH-1:0]       w_post;

  // While a result is held, input is only taken if that result leaves this cycle.
  assign in_ready  = (r_state == S_ACC) | out_ready;
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_out_data;
  assign sat_flag  = r_sat;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign w_din_ext  = {{(ACC_WIDTH - DIN_WIDTH){in_data[DIN_WIDTH-1]}}, in_data};
  assign w_base     = (r_cnt == '0) ? w_bias_ext : r_acc;
  assign w_sum      = w_base + w_din_ext;

  // One extra bit so the rounding add cannot wrap.
  assign w_rnd  = {w_sum[ACC_WIDTH-1], w_sum} + HALF;
  assign w_shr  = w_rnd >>> SHIFT;
  assign w_neg  = w_shr[PW-1];
  assign w_ovf  = !w_neg && (w_shr > MAX_OUT);
  assign w_post = w_neg ? '0 : (w_ovf ? MAX_OUT[DOUT_WIDTH-1:0] : w_shr[DOUT_WIDTH-1:0]);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_ACC;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_sat      <= 1'b0;
    end else if (w_in_xfer) begin
      if (w_last) begin
        r_cnt      <= '0;
        r_out_data <= w_post;
        r_state    <= S_OUT;
        if (w_ovf) begin
          r_sat <= 1'b1;
        end
      end else begin
        r_acc   <= w_sum;
        r_cnt   <= r_cnt + 1'b1;
        r_state <= S_ACC;
      end
    end else if ((r_state == S_OUT) && out_ready) begin
      r_state <= S_ACC;
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc_relu.sv
// Scoreboard bench for myproject_dense_acc_relu: a behavioural model queues
// expected results as terms are accepted; a monitor pops them on each output transfer.
module tb_myproject_dense_acc_relu;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic signed [15:0] bias = '0;
  logic signed [22:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        out_data;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  longint      m_acc = 0;
  int          m_cnt = 0;
  logic        m_sat = 1'b0;

  myproject_dense_acc_relu dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .bias      (bias),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  // Behavioural reference: plain integer arithmetic, wrapped to 27 bits.
  task automatic model_accept(input logic signed [22:0] d, input logic signed [15:0] b);
    longint s;
    longint r;
    s = ((m_cnt == 0) ? longint'(b) : m_acc) + longint'(d);
    s = (s <<< 37) >>> 37;
    if (m_cnt == 8) begin
      r = (s + 64) >>> 7;
      if (r < 0) r = 0;
      else if (r > 32767) begin
        r = 32767;
        m_sat = 1'b1;
      end
      exp_q.push_back(16'(r));
      m_cnt = 0;
    end else begin
      m_acc = s;
      m_cnt++;
    end
  endtask

  // Outputs and inputs are stable at the falling edge, so what is seen here
  // is exactly what transfers at the next rising edge.
  always @(negedge ap_clk) begin
    logic [15:0] e;
    if (ap_rst_n && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got=%0d required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL output_data got=%0d required=%0d", out_data, e);
        end else begin
          $display("[TB] output %0d ok", out_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic signed [22:0] d, input logic signed [15:0] b);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      model_accept(d, b);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 23'h5A5A5;
    bias     = 16'sh7BCD;
  endtask

  task automatic send9(input logic signed [22:0] d, input logic signed [15:0] b);
    for (int i = 0; i < 9; i++) send(d, b);
  endtask

  task automatic test_reset();
    n_tests += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d required=0", out_data); end
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got=%0b required=0", sat_flag); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send9(23'sd128, 16'sd0);
    n_tests += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid=%0b required=1", out_valid); end
    if (out_data !== 16'd9) begin n_fail++; $display("FAIL basic_value got=%0d required=9", out_data); end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain out_valid=%0b required=0", out_valid); end
  endtask

  task automatic test_rounding();
    out_ready = 1'b1;
    send(23'sd64, 16'sd0);  for (int i = 0; i < 8; i++) send(23'sd0, 16'sd0);
    send(23'sd63, 16'sd0);  for (int i = 0; i < 8; i++) send(23'sd0, 16'sd0);
    send(23'sd64, -16'sd64); for (int i = 0; i < 8; i++) send(23'sd0, 16'sd0);
    tick();
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(23'sd300, 16'sd0);
      tick();
      tick();
    end
  endtask

  task automatic test_relu();
    out_ready = 1'b1;
    send9(-23'sd1000, 16'sd0);
    n_tests += 2;
    if (out_data !== 16'd0) begin n_fail++; $display("FAIL relu_value got=%0d required=0", out_data); end
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL relu_sat_flag got=%0b required=0", sat_flag); end
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    send9(23'sd4194303, 16'sd0);
    n_tests += 2;
    if (out_data !== 16'd32767) begin n_fail++; $display("FAIL sat_value got=%0d required=32767", out_data); end
    if (sat_flag !== m_sat) begin n_fail++; $display("FAIL sat_flag_set got=%0b required=%0b", sat_flag, m_sat); end
    send9(23'sd128, 16'sd0);
    tick();
    n_tests++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag_sticky got=%0b required=1", sat_flag); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send9(23'sd256, 16'sd0);
    in_valid = 1'b1;
    in_data  = 23'sd7777;
    bias     = 16'sd1111;
    for (int i = 0; i < 5; i++) begin
      n_tests += 3;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%0b required=1", i, out_valid); end
      if (out_data !== 16'd18) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%0d required=18", i, out_data); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%0b required=0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    send9(23'sd128, 16'sd640);
    n_tests++;
    if (out_data !== 16'd14) begin n_fail++; $display("FAIL bp_next_value got=%0d required=14", out_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(23'sd128, 16'sd0);
    ap_rst_n = 1'b0;
    m_cnt = 0;
    m_acc = 0;
    m_sat = 1'b0;
    #2;
    n_tests += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%0b required=0", out_valid); end
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL midrst_sat_flag got=%0b required=0", sat_flag); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%0b required=1", in_ready); end
    tick();
    ap_rst_n = 1'b1;
    send9(23'sd128, 16'sd0);
    n_tests++;
    if (out_data !== 16'd9) begin n_fail++; $display("FAIL midrst_value got=%0d required=9", out_data); end
    tick();
  endtask

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    test_reset();
    ap_rst_n = 1'b1;
    tick();
    test_basic();
    test_rounding();
    test_gaps();
    test_relu();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
